// File: rtl/gtp_grs.sv
// Global reset/set generator: synchronises and filters GRS_N, holds grs_o, then releases domains in order.
// Optional event counter built when GRS_EVT_CNT_EN is defined.
module gtp_grs #(
  parameter int unsigned SYNC_STAGES   = 2,
  parameter int unsigned FILTER_CYCLES = 4,
  parameter int unsigned HOLD_CYCLES   = 16,
  parameter int unsigned NUM_DOMAINS   = 4,
  parameter int unsigned STAGE_GAP     = 2,
  parameter int unsigned CNT_WIDTH     = 8
) (
  input  logic                   video_clk,
  input  logic                   rst,
  input  logic                   GRS_N,
  output logic                   grs_o,
  output logic                   grs_n_o,
  output logic [NUM_DOMAINS-1:0] dom_rst_o,
  output logic                   grs_ready,
  output logic [CNT_WIDTH-1:0]   grs_evt_cnt
);

  localparam int unsigned LOW_W    = $clog2(FILTER_CYCLES + 1);
  localparam int unsigned HOLD_W   = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam int unsigned REL_LAST = (NUM_DOMAINS - 1) * STAGE_GAP;
  localparam int unsigned REL_W    = (REL_LAST > 0) ? $clog2(REL_LAST + 1) : 1;

  typedef enum logic [1:0] {ASSERT, HOLD, RELEASE, RUN} state_t;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s_n;
  logic [LOW_W-1:0]       low_cnt_q;
  logic                   req;
  state_t                 state_q, state_d;
  logic [HOLD_W-1:0]      hold_cnt_q, hold_cnt_d;
  logic [REL_W-1:0]       rel_cnt_q, rel_cnt_d;
  logic [NUM_DOMAINS-1:0] dom_rst_d;

  assign s_n = sync_q[SYNC_STAGES-1];
  assign req = (low_cnt_q == LOW_W'(FILTER_CYCLES));

  // Synchroniser and low-level glitch filter
  always_ff @(posedge video_clk) begin
    if (rst) begin
      sync_q    <= '1;
      low_cnt_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], GRS_N};
      if (s_n)
        low_cnt_q <= '0;
      else if (!req)
        low_cnt_q <= low_cnt_q + LOW_W'(1);
    end
  end

  // State and counters; outputs are registered from the next-state decode
  always_ff @(posedge video_clk) begin
    if (rst) begin
      state_q    <= ASSERT;
      hold_cnt_q <= '0;
      rel_cnt_q  <= '0;
      grs_o      <= 1'b1;
      grs_n_o    <= 1'b0;
      dom_rst_o  <= '1;
      grs_ready  <= 1'b0;
    end else begin
      state_q    <= state_d;
      hold_cnt_q <= hold_cnt_d;
      rel_cnt_q  <= rel_cnt_d;
      grs_o      <= (state_d == ASSERT) || (state_d == HOLD);
      grs_n_o    <= !((state_d == ASSERT) || (state_d == HOLD));
      dom_rst_o  <= dom_rst_d;
      grs_ready  <= (state_d == RUN);
    end
  end

  // Next state; a live request overrides any count-based transition
  always_comb begin
    state_d    = state_q;
    hold_cnt_d = hold_cnt_q;
    rel_cnt_d  = rel_cnt_q;
    unique case (state_q)
      ASSERT: begin
        hold_cnt_d = '0;
        if (!req) state_d = HOLD;
      end
      HOLD: begin
        hold_cnt_d = hold_cnt_q + HOLD_W'(1);
        if (req) begin
          state_d = ASSERT;
        end else if (hold_cnt_q == HOLD_W'(HOLD_CYCLES - 1)) begin
          state_d   = (REL_LAST == 0) ? RUN : RELEASE;
          rel_cnt_d = '0;
        end
      end
      RELEASE: begin
        rel_cnt_d = rel_cnt_q + REL_W'(1);
        if (req)
          state_d = ASSERT;
        else if (rel_cnt_d == REL_W'(REL_LAST))
          state_d = RUN;
      end
      RUN: begin
        if (req) state_d = ASSERT;
      end
      default: state_d = ASSERT;
    endcase
  end

  // Staged domain release: domain i leaves reset once rel_cnt reaches i*STAGE_GAP
  always_comb begin
    dom_rst_d = '1;
    for (int unsigned i = 0; i < NUM_DOMAINS; i++) begin
      if (state_d == RUN)
        dom_rst_d[i] = 1'b0;
      else if (state_d == RELEASE && 32'(rel_cnt_d) >= i * STAGE_GAP)
        dom_rst_d[i] = 1'b0;
    end
  end

`ifdef GRS_EVT_CNT_EN
  // Count entries into ASSERT from any other state, saturating
  always_ff @(posedge video_clk) begin
    if (rst)
      grs_evt_cnt <= '0;
    else if (state_q != ASSERT && state_d == ASSERT && grs_evt_cnt != '1)
      grs_evt_cnt <= grs_evt_cnt + CNT_WIDTH'(1);
  end
`else
  assign grs_evt_cnt = '0;
`endif

endmodule

// File: tb/tb_gtp_grs.sv
// Directed bench for gtp_grs: expected outputs are queued per cycle and checked as cycles elapse.
module tb_gtp_grs;

  logic       video_clk = 1'b0;
  logic       rst;
  logic       GRS_N;
  logic       grs_o;
  logic       grs_n_o;
  logic [3:0] dom_rst_o;
  logic       grs_ready;
  logic [7:0] grs_evt_cnt;

  always #5 video_clk = ~video_clk;

  gtp_grs dut (
    .video_clk  (video_clk),
    .rst        (rst),
    .GRS_N      (GRS_N),
    .grs_o      (grs_o),
    .grs_n_o    (grs_n_o),
    .dom_rst_o  (dom_rst_o),
    .grs_ready  (grs_ready),
    .grs_evt_cnt(grs_evt_cnt)
  );

  typedef struct {
    int unsigned cyc;
    logic [14:0] exp;
    string       tag;
  } exp_t;

  exp_t        sb[$];
  int unsigned cyc;
  int          checks;
  int          errors;

  function automatic logic [7:0] ec(int n);
`ifdef GRS_EVT_CNT_EN
    return (n > 255) ? 8'd255 : 8'(n);
`else
    return 8'd0;
`endif
  endfunction

  task automatic push(input int unsigned c, input logic g, input logic [3:0] d,
                      input logic r, input logic [7:0] n, input string tag);
    exp_t e;
    int   idx;
    e.cyc = c;
    e.exp = {g, ~g, d, r, n};
    e.tag = tag;
    idx = sb.size();
    for (int i = 0; i < sb.size(); i++) begin
      if (sb[i].cyc > c) begin
        idx = i;
        break;
      end
    end
    sb.insert(idx, e);
  endtask

  task automatic tick();
    exp_t        e;
    logic [14:0] obs;
    @(posedge video_clk);
    #1;
    cyc++;
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      e   = sb.pop_front();
      obs = {grs_o, grs_n_o, dom_rst_o, grs_ready, grs_evt_cnt};
      checks++;
      assert (e.cyc == cyc && obs === e.exp) else begin
        errors++;
        $error("FAIL %s cyc %0d observed %h expected %h", e.tag, cyc, obs, e.exp);
      end
    end
  endtask

  task automatic run(input int n);
    repeat (n) tick();
  endtask

  initial begin
    int unsigned c0, r, rr, r2;
    cyc    = 0;
    checks = 0;
    errors = 0;
    rst    = 1'b1;
    GRS_N  = 1'b1;

    // Reset values, then power-up release sequence
    push(1, 1'b1, 4'hF, 1'b0, 8'd0, "rst_vals");
    push(3, 1'b1, 4'hF, 1'b0, 8'd0, "rst_vals_end");
    run(3);
    rst = 1'b0;
    c0  = cyc;
    push(c0 + 1,  1'b1, 4'hF, 1'b0, ec(0), "hold_e1");
    push(c0 + 16, 1'b1, 4'hF, 1'b0, ec(0), "hold_e16");
    push(c0 + 17, 1'b0, 4'hE, 1'b0, ec(0), "rel_e17");
    push(c0 + 18, 1'b0, 4'hE, 1'b0, ec(0), "rel_e18");
    push(c0 + 19, 1'b0, 4'hC, 1'b0, ec(0), "rel_e19");
    push(c0 + 20, 1'b0, 4'hC, 1'b0, ec(0), "rel_e20");
    push(c0 + 21, 1'b0, 4'h8, 1'b0, ec(0), "rel_e21");
    push(c0 + 22, 1'b0, 4'h8, 1'b0, ec(0), "rel_e22");
    push(c0 + 23, 1'b0, 4'h0, 1'b1, ec(0), "run_e23");
    run(25);

    // Three-cycle glitch is filtered out
    c0 = cyc;
    GRS_N = 1'b0;
    for (int i = 1; i <= 12; i++) push(c0 + i, 1'b0, 4'h0, 1'b1, ec(0), "short_pulse");
    run(3);
    GRS_N = 1'b1;
    run(9);

    // Accepted request: seven-edge latency, held in ASSERT, full hold after removal
    c0 = cyc;
    GRS_N = 1'b0;
    push(c0 + 6,  1'b0, 4'h0, 1'b1, ec(0), "req_pre");
    push(c0 + 7,  1'b1, 4'hF, 1'b0, ec(1), "req_lat");
    push(c0 + 15, 1'b1, 4'hF, 1'b0, ec(1), "req_held");
    run(20);
    r = cyc;
    GRS_N = 1'b1;
    push(r + 4,  1'b1, 4'hF, 1'b0, ec(1), "hold_start");
    push(r + 19, 1'b1, 4'hF, 1'b0, ec(1), "hold_end");
    push(r + 20, 1'b0, 4'hE, 1'b0, ec(1), "rerelease");
    push(r + 26, 1'b0, 4'h0, 1'b1, ec(1), "rerun");
    run(27);

    // Request landing mid-RELEASE reasserts every domain and restarts hold
    GRS_N = 1'b0;
    run(10);
    r = cyc;
    GRS_N = 1'b1;
    rr = r + 20;
    run(18);
    GRS_N = 1'b0;
    push(rr + 4, 1'b0, 4'h8, 1'b0, ec(2), "rel_mid");
    push(rr + 5, 1'b1, 4'hF, 1'b0, ec(3), "rel_abort");
    run(20);
    r2 = cyc;
    GRS_N = 1'b1;
    push(r2 + 19, 1'b1, 4'hF, 1'b0, ec(3), "rehold_full");
    push(r2 + 20, 1'b0, 4'hE, 1'b0, ec(3), "rehold_rel");
    run(20);

    // rst pulse while releasing
    rst = 1'b1;
    push(cyc + 1, 1'b1, 4'hF, 1'b0, 8'd0, "rst_mid");
    tick();
    rst = 1'b0;
    c0 = cyc;
    push(c0 + 17, 1'b0, 4'hE, 1'b0, 8'd0, "post_rst_rel");
    push(c0 + 23, 1'b0, 4'h0, 1'b1, 8'd0, "post_rst_run");
    run(24);

    // Counter saturation over 300 accepted requests
    for (int k = 0; k < 300; k++) begin
      if (k == 10) push(cyc + 1, 1'b1, 4'hF, 1'b0, ec(10), "cnt10");
      GRS_N = 1'b0;
      run(5);
      GRS_N = 1'b1;
      run(5);
    end
    push(cyc + 1, 1'b1, 4'hF, 1'b0, ec(300), "cnt_sat");
    push(cyc + 22, 1'b0, 4'h0, 1'b1, ec(300), "cnt_sat_run");
    run(25);

    while (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      checks++;
      errors++;
      $display("FAIL %s never reached (cycle %0d) observed none expected %h", e.tag, e.cyc, e.exp);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
